dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the pipelined RV32 core. It sits on the core's MEM-stage data port and serves address, write data, mem_w, DMType and read-data.
- Provides word-addressed storage with byte and halfword lane handling, load sign/zero extension, and alignment and range checking.
- Keeps a sticky fault capture register and saturating load/store counters for bring-up and debug.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the array; must be a power of two.
- AW, 7, word-index width; equals log2(DEPTH_WORDS).
- CNT_W, 16, width of the load and store counters.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; synchronous, active-low.
- mem_w  in  1  store request, from EX/MEM.
- mem_r  in  1  load request, from EX/MEM MemRead.
- Addr_in  in  32  byte address, the ALU result.
- Data_in  in  32  store data (rs2 data).
- DMType  in  3  access type.
- Data_out  out  32  formatted load data, to the core's read-data input.
- fault  out  1  sticky access-fault flag.
- fault_addr  out  32  address of the first fault since the last clear.
- fault_clr  in  1  clears fault and fault_addr.
- ld_cnt  out  CNT_W  count of accepted loads.
- st_cnt  out  CNT_W  count of accepted stores.

Behaviour:
- Reset (rst==0 at a clk edge):
  - fault=0, fault_addr=0, ld_cnt=0, st_cnt=0.
  - Array contents are not reset.
  - Writes are suppressed during that edge.
- Word index is Addr_in[AW+1:2].
- An access is in range when Addr_in < 4*DEPTH_WORDS.
- Read path is combinational, zero latency, because MEM/WB latches read data in the same cycle the address is presented.
  - Data_out = format(array[idx], Addr_in[1:0], DMType) when mem_r is high and the access is legal; otherwise 0.
- Load formatting:
  - word: the word unchanged.
  - half: select bits [15:0] or [31:16] by Addr_in[1]; sign-extend.
  - half unsigned: same lane selection; zero-extend.
  - byte: select lane Addr_in[1:0]; sign-extend.
  - byte unsigned: same lane selection; zero-extend.
- Store path writes at the rising clk edge when mem_w & legal & rst.
  - Byte enables: word = 4'b1111; half = 4'b0011 << (2*Addr_in[1]); byte = 4'b0001 << Addr_in[1:0].
  - Store data is taken from Data_in[7:0], [15:0] or [31:0] and replicated into the enabled lane.
  - Unsigned store types behave as the signed type of the same size.
- Legal access requires all of:
  - in range;
  - DMType is one of the five defined codes;
  - word: Addr_in[1:0]==0;
  - half: Addr_in[0]==0;
  - byte: always aligned.
- Illegal access (mem_w|mem_r high and not legal):
  - No write; Data_out=0.
  - If fault==0: set fault=1 and capture fault_addr=Addr_in at that edge.
  - If fault==1 already: hold the captured address (first-fault wins).
- fault_clr: at the next edge, fault=0 and fault_addr=0, unless a new illegal access occurs in the same cycle; in that case set wins and the new address is captured.
- Counters:
  - ld_cnt increments on a legal mem_r; st_cnt increments on a legal mem_w.
  - Both saturate at all-ones (no wrap).
- mem_w and mem_r high together: the store is performed and counted in st_cnt only; Data_out reflects the pre-write contents for that cycle (read-before-write).
- A load in the cycle after a store to the same word sees the new data; no extra latency.
- No handshake and no stall output; every legal access completes in one cycle.

Decomposition:
- Shared package dm_pkg holds the DMType codes: DM_WORD=3'b000, DM_HALF=3'b001, DM_HALF_U=3'b010, DM_BYTE=3'b011, DM_BYTE_U=3'b100. It also holds the legality and byte-enable helper constants.
- The core control unit uses the same package.
- One natural sub-module: dm_lane_fmt, the combinational load extract/extend unit (word, Addr[1:0], DMType -> Data_out).

Test Plan:
- Store word 0xDEADBEEF @0x10, then load byte @0x13 signed -> 0xFFFFFFDE; byte unsigned @0x12 -> 0x000000AD; half @0x10 -> 0xFFFFBEEF.
- Store byte 0x5A @0x21 over word 0x11223344, then load word @0x20 -> 0x11225A44; st_cnt=2, ld_cnt=1.
- Load word @0x22 -> Data_out=0, fault=1, fault_addr=0x22; then store half @0x31 -> fault_addr stays 0x22 and the word @0x30 is unchanged.
- fault_clr together with an illegal load @0x1000 (out of range, DEPTH_WORDS=128) -> fault=1, fault_addr=0x1000; fault_clr alone -> fault=0, fault_addr=0.
- Preset ld_cnt to 0xFFFE, then 3 legal loads -> ld_cnt=0xFFFF and holds.
- rst low for one edge mid-sequence with mem_w high @0x40 -> no write, counters and fault cleared, earlier array data intact.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory port.
// Contents: the DMType access codes, the byte-enable base patterns, and helper
// functions that decide whether a type code is defined, whether an access is
// aligned, and which byte lanes an access touches.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  function automatic logic type_valid(input logic [2:0] t);
    return (t <= 3'b100);
  endfunction

  function automatic logic type_aligned(input logic [2:0] t, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (t)
      DM_WORD:             ok = (a == 2'b00);
      DM_HALF, DM_HALF_U:  ok = ~a[0];
      DM_BYTE, DM_BYTE_U:  ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (t)
      DM_WORD:             be = BE_WORD;
      DM_HALF, DM_HALF_U:  be = BE_HALF << {a[1], 1'b0};
      DM_BYTE, DM_BYTE_U:  be = BE_BYTE << a;
      default:             be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Data-memory port between the core's MEM stage and dm_responder.
// master: the core (drives mem_w, mem_r, Addr_in, Data_in, DMType; receives Data_out).
// slave:  the responder (the reverse directions).
interface dm_responder_if;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  DMType;
  logic [31:0] Data_out;

  modport master (output mem_w, mem_r, Addr_in, Data_in, DMType, input Data_out);
  modport slave  (input mem_w, mem_r, Addr_in, Data_in, DMType, output Data_out);
endinterface

// File: rtl/dm_lane_fmt.sv
// Load formatter: extracts the addressed byte or halfword from a stored word
// and sign- or zero-extends it according to the access type.
// Ports: word (raw array word), offs (Addr_in[1:0]), dm_type (DMType),
//        data (formatted 32-bit load value).
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offs,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  lane;

  always_comb begin
    half = offs[1] ? word[31:16] : word[15:0];
    case (offs)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
  end

  always_comb begin
    data = word;
    case (dm_type)
      DM_HALF:   data = {{16{half[15]}}, half};
      DM_HALF_U: data = {16'h0000, half};
      DM_BYTE:   data = {{24{lane[7]}}, lane};
      DM_BYTE_U: data = {24'h000000, lane};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the RV32 MEM stage: word array with byte/halfword
// lanes, zero-latency formatted loads, sticky first-fault capture and
// saturating load/store counters.
// Ports: clk, rst (sync, active-low), bus (dm_responder_if.slave),
//        fault_clr, fault, fault_addr, ld_cnt, st_cnt.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 7,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  dm_responder_if.slave    bus,
  input  logic             fault_clr,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          legal;
  logic          illegal;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   fmt_data;

  assign idx     = bus.Addr_in[AW+1:2];
  assign legal   = (bus.Addr_in < ADDR_LIMIT) && type_valid(bus.DMType)
                   && type_aligned(bus.DMType, bus.Addr_in[1:0]);
  assign illegal = (bus.mem_w | bus.mem_r) & ~legal;
  assign be      = byte_en(bus.DMType, bus.Addr_in[1:0]);
  assign rd_word = mem[idx];

  // Replicate the store data across all lanes; the byte enables pick the lane.
  always_comb begin
    wdata = bus.Data_in;
    case (bus.DMType)
      DM_HALF, DM_HALF_U: wdata = {2{bus.Data_in[15:0]}};
      DM_BYTE, DM_BYTE_U: wdata = {4{bus.Data_in[7:0]}};
      default:            wdata = bus.Data_in;
    endcase
  end

  dm_lane_fmt u_fmt (
    .word    (rd_word),
    .offs    (bus.Addr_in[1:0]),
    .dm_type (bus.DMType),
    .data    (fmt_data)
  );

  // Read is combinational from the pre-edge array contents, so a simultaneous
  // store is naturally read-before-write.
  assign bus.Data_out = (bus.mem_r && legal) ? fmt_data : 32'h0;

  // Array has no reset; only the write is gated by rst.
  always_ff @(posedge clk) begin
    if (rst && bus.mem_w && legal) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
      ld_cnt     <= '0;
      st_cnt     <= '0;
    end else begin
      // A new fault overrides a pending clear; otherwise the first fault holds.
      if (illegal) begin
        if (!fault || fault_clr) begin
          fault      <= 1'b1;
          fault_addr <= bus.Addr_in;
        end
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_addr <= 32'h0;
      end

      if (bus.mem_w && legal) begin
        if (st_cnt != '1) st_cnt <= st_cnt + 1'b1;
      end else if (bus.mem_r && legal) begin
        if (ld_cnt != '1) ld_cnt <= ld_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_clr;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] ld_cnt;
  logic [15:0] st_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  dm_responder_if bus ();

  dm_responder #(.DEPTH_WORDS(128), .AW(7), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_addr (fault_addr),
    .ld_cnt     (ld_cnt),
    .st_cnt     (st_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] t);
    bus.mem_w   = w;
    bus.mem_r   = r;
    bus.Addr_in = a;
    bus.Data_in = d;
    bus.DMType  = t;
    #1;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    fault_clr = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_faddr", fault_addr, 32'h0);
    chk("rst_ld", {16'h0, ld_cnt}, 32'h0);
    chk("rst_st", {16'h0, st_cnt}, 32'h0);
    rst = 1'b1;

    acc(1, 0, 32'h10, 32'hDEADBEEF, DM_WORD); tick();
    acc(0, 1, 32'h13, 32'h0, DM_BYTE);   chk("ld_b_s", bus.Data_out, 32'hFFFFFFDE); tick();
    acc(0, 1, 32'h12, 32'h0, DM_BYTE_U); chk("ld_b_u", bus.Data_out, 32'h000000AD); tick();
    acc(0, 1, 32'h10, 32'h0, DM_HALF);   chk("ld_h_s", bus.Data_out, 32'hFFFFBEEF); tick();
    acc(0, 1, 32'h12, 32'h0, DM_HALF_U); chk("ld_h_u", bus.Data_out, 32'h0000DEAD); tick();

    acc(1, 0, 32'h20, 32'h11223344, DM_WORD); tick();
    acc(1, 0, 32'h21, 32'hFFFFFF5A, DM_BYTE); tick();
    acc(0, 1, 32'h20, 32'h0, DM_WORD); chk("ld_w_merge", bus.Data_out, 32'h11225A44); tick();
    chk("cnt_st_a", {16'h0, st_cnt}, 32'd3);
    chk("cnt_ld_a", {16'h0, ld_cnt}, 32'd5);

    acc(1, 0, 32'h30, 32'h01020304, DM_WORD); tick();
    acc(0, 1, 32'h22, 32'h0, DM_WORD); chk("misal_data", bus.Data_out, 32'h0); tick();
    chk("misal_fault", {31'h0, fault}, 32'h1);
    chk("misal_faddr", fault_addr, 32'h22);
    chk("misal_ld", {16'h0, ld_cnt}, 32'd5);
    acc(1, 0, 32'h31, 32'h0000FFFF, DM_HALF); tick();
    chk("first_wins", fault_addr, 32'h22);
    chk("misal_st", {16'h0, st_cnt}, 32'd4);
    acc(0, 1, 32'h30, 32'h0, 3'b111); chk("badtype_data", bus.Data_out, 32'h0); tick();
    chk("badtype_hold", fault_addr, 32'h22);
    acc(0, 1, 32'h30, 32'h0, DM_WORD); chk("no_write", bus.Data_out, 32'h01020304); tick();

    fault_clr = 1'b1;
    acc(0, 1, 32'h1000, 32'h0, DM_WORD); chk("oor_data", bus.Data_out, 32'h0); tick();
    chk("clr_set_f", {31'h0, fault}, 32'h1);
    chk("clr_set_a", fault_addr, 32'h1000);
    idle(); tick();
    fault_clr = 1'b0;
    chk("clr_f", {31'h0, fault}, 32'h0);
    chk("clr_a", fault_addr, 32'h0);

    acc(1, 0, 32'h32, 32'h1234ABCD, DM_HALF); tick();
    acc(0, 1, 32'h30, 32'h0, DM_WORD); chk("st_half", bus.Data_out, 32'hABCD0304); tick();
    acc(1, 1, 32'h30, 32'h00000055, DM_WORD); chk("rbw", bus.Data_out, 32'hABCD0304); tick();
    chk("rw_st", {16'h0, st_cnt}, 32'd6);
    chk("rw_ld", {16'h0, ld_cnt}, 32'd7);
    acc(0, 1, 32'h30, 32'h0, DM_WORD); chk("raw_next", bus.Data_out, 32'h00000055); tick();

    acc(1, 0, 32'h40, 32'h12345678, DM_WORD); tick();
    acc(0, 1, 32'h41, 32'h0, DM_WORD); tick();
    chk("pre_rst_f", {31'h0, fault}, 32'h1);
    rst = 1'b0;
    acc(1, 0, 32'h40, 32'h00000099, DM_WORD); tick();
    rst = 1'b1;
    idle();
    chk("mid_rst_f", {31'h0, fault}, 32'h0);
    chk("mid_rst_a", fault_addr, 32'h0);
    chk("mid_rst_st", {16'h0, st_cnt}, 32'h0);
    chk("mid_rst_ld", {16'h0, ld_cnt}, 32'h0);
    acc(0, 1, 32'h40, 32'h0, DM_WORD); chk("rst_nowrite", bus.Data_out, 32'h12345678); tick();
    acc(0, 1, 32'h10, 32'h0, DM_WORD); chk("rst_keep", bus.Data_out, 32'hDEADBEEF); tick();

    acc(0, 1, 32'h10, 32'h0, DM_WORD);
    repeat (65532) @(posedge clk);
    #1;
    chk("ld_fffe", {16'h0, ld_cnt}, 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("ld_sat", {16'h0, ld_cnt}, 32'h0000FFFF);
    chk("st_zero", {16'h0, st_cnt}, 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
